// File: rtl/aidc_lite_sched_pkg.sv
// Shared constants and FSM state type for the ZRLE compressor scheduler.
// Block, word and beat geometry are fixed by the compressor datapath.
package aidc_lite_sched_pkg;

    localparam int BLK_W  = 512;
    localparam int WORD_W = 64;
    localparam int BEATS  = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_RESP
    } state_t;

endpackage

// File: rtl/aidc_lite_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or
// after i_ptr (cyclic). Ports: i_req, i_ptr in; o_gnt (one-hot), o_id out.
module aidc_lite_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_id
);

    int w_dist;
    int w_best;

    // Pick the requesting index with the smallest cyclic distance from
    // the pointer; only constant indices are used so no wrap arithmetic
    // is needed on the vector itself.
    always_comb begin
        w_best = NUM_REQ;
        w_dist = 0;
        o_id   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_dist = k - int'(i_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_REQ;
            end
            if (i_req[k] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_id   = ID_W'(k);
            end
        end
        o_gnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_gnt[k] = i_req[k] && (o_id == ID_W'(k));
        end
    end

endmodule

// File: rtl/aidc_lite_comp_sched.sv
// Shares one ZRLE compressor among NUM_REQ block requesters: round-robin
// grant, 8-beat feed, drain, capture of addressed output words, and a
// valid/ready response carrying either the compressed or the raw block.
// Ports: req_* (requesters), comp_*_o (to compressor), comp_*_i (from
// compressor), rsp_* (result to granted requester).
module aidc_lite_comp_sched
    import aidc_lite_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DRAIN_CYC = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*BLK_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     comp_valid_o,
    output logic                     comp_sop_o,
    output logic                     comp_eop_o,
    output logic [WORD_W-1:0]        comp_data_o,
    input  logic                     comp_valid_i,
    input  logic [3:0]               comp_addr_i,
    input  logic [WORD_W-1:0]        comp_data_i,
    input  logic                     comp_fail_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic                     rsp_raw_o,
    output logic [3:0]               rsp_words_o,
    output logic [BLK_W-1:0]         rsp_data_o
);

    state_t             r_state;
    state_t             w_next;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [BLK_W-1:0]   r_blk;
    logic [BLK_W-1:0]   r_buf;
    logic [3:0]         r_beat;
    logic [3:0]         r_drain;
    logic [2:0]         r_max;
    logic               r_fail;
    logic               r_any;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_grant;
    logic               w_window;
    logic               w_raw;

    aidc_lite_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req (req_valid_i),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_id  (w_gnt_id)
    );

    // No grant is offered while reset is held.
    assign w_grant  = (r_state == S_IDLE) && (|req_valid_i) && !rst;
    assign w_window = (r_state == S_FEED) || (r_state == S_DRAIN);
    // An empty capture is as unusable as an overflow: return raw.
    assign w_raw    = r_fail || !r_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) w_next = S_FEED;
            end
            S_FEED: begin
                if (r_beat == 4'(BEATS - 1)) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_drain == 4'(DRAIN_CYC - 1)) w_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = w_grant ? w_gnt : '0;
        comp_valid_o = (r_state == S_FEED);
        comp_sop_o   = (r_state == S_FEED) && (r_beat == 4'd0);
        comp_eop_o   = (r_state == S_FEED) && (r_beat == 4'(BEATS - 1));
        comp_data_o  = '0;
        rsp_valid_o  = (r_state == S_RESP);
        rsp_id_o     = '0;
        rsp_raw_o    = 1'b0;
        rsp_words_o  = '0;
        rsp_data_o   = '0;
        if (r_state == S_FEED) begin
            comp_data_o = r_blk[int'(r_beat[2:0]) * WORD_W +: WORD_W];
        end
        if (r_state == S_RESP) begin
            rsp_id_o    = r_id;
            rsp_raw_o   = w_raw;
            rsp_words_o = w_raw ? 4'd8 : ({1'b0, r_max} + 4'd1);
            rsp_data_o  = w_raw ? r_blk : r_buf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_blk   <= '0;
            r_buf   <= '0;
            r_beat  <= '0;
            r_drain <= '0;
            r_max   <= '0;
            r_fail  <= 1'b0;
            r_any   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_blk   <= req_data_i[int'(w_gnt_id) * BLK_W +: BLK_W];
                        r_id    <= w_gnt_id;
                        r_buf   <= '0;
                        r_fail  <= 1'b0;
                        r_any   <= 1'b0;
                        r_max   <= '0;
                        r_beat  <= '0;
                        r_drain <= '0;
                        r_ptr   <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ?
                                   '0 : w_gnt_id + ID_W'(1);
                    end
                end
                S_FEED:  r_beat  <= r_beat + 4'd1;
                S_DRAIN: r_drain <= r_drain + 4'd1;
                default: ;
            endcase
            if (w_window) begin
                if (comp_valid_i) begin
                    // Index 8+ means the output outgrew the block.
                    if (comp_addr_i[3]) begin
                        r_fail <= 1'b1;
                    end else begin
                        r_buf[int'(comp_addr_i[2:0]) * WORD_W +: WORD_W] <= comp_data_i;
                        r_any <= 1'b1;
                        if (comp_addr_i[2:0] > r_max) r_max <= comp_addr_i[2:0];
                    end
                end
                if (comp_fail_i) r_fail <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aidc_lite_comp_sched.sv
// Self-checking bench for aidc_lite_comp_sched: table of block vectors,
// a compressor stand-in, and a response scoreboard queue.
module tb_aidc_lite_comp_sched;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid_i;
    logic [N*512-1:0] req_data_i;
    logic [N-1:0]   req_ready_o;
    logic           comp_valid_o;
    logic           comp_sop_o;
    logic           comp_eop_o;
    logic [63:0]    comp_data_o;
    logic           comp_valid_i;
    logic [3:0]     comp_addr_i;
    logic [63:0]    comp_data_i;
    logic           comp_fail_i;
    logic           rsp_valid_o;
    logic           rsp_ready_i;
    logic [IW-1:0]  rsp_id_o;
    logic           rsp_raw_o;
    logic [3:0]     rsp_words_o;
    logic [511:0]   rsp_data_o;

    aidc_lite_comp_sched #(
        .NUM_REQ   (N),
        .DRAIN_CYC (D),
        .ID_W      (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .comp_valid_o (comp_valid_o),
        .comp_sop_o   (comp_sop_o),
        .comp_eop_o   (comp_eop_o),
        .comp_data_o  (comp_data_o),
        .comp_valid_i (comp_valid_i),
        .comp_addr_i  (comp_addr_i),
        .comp_data_i  (comp_data_i),
        .comp_fail_i  (comp_fail_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_raw_o    (rsp_raw_o),
        .rsp_words_o  (rsp_words_o),
        .rsp_data_o   (rsp_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [511:0] blk;
        int           mode;
        logic         raw;
        logic [3:0]   words;
    } vec_t;

    typedef struct {
        logic [IW-1:0] id;
        logic          raw;
        logic [3:0]    words;
        logic [511:0]  data;
    } rsp_t;

    rsp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[5];

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Compressor stand-in: what it emits on window cycle c (0..7 feed,
    // 8.. drain) for each scripted mode.
    task automatic cmodel(input int mode, input int c, output logic v,
                          output logic [3:0] a, output logic [63:0] d,
                          output logic f);
        v = 1'b0; a = '0; d = '0; f = 1'b0;
        case (mode)
            0: if (c == 8) begin
                v = 1'b1; a = 4'd0; d = 64'hA5A5;
            end
            1: if (c <= 8) begin
                v = 1'b1; a = 4'(c);
                d = 64'hC0DE_0000_0000_0000 | 64'(c);
                f = (c == 8);
            end
            2: if (c == 9) begin
                v = 1'b1; a = 4'd3; d = 64'hDEAD_BEEF_1234_5678;
            end
            4: if (c >= 2 && c <= 4) begin
                v = 1'b1; a = 4'(c - 2); d = 64'h1111 * 64'(c);
            end else if (c == 11) begin
                v = 1'b1; a = 4'd1; d = 64'h7777;
            end
            default: ;
        endcase
    endtask

    task automatic run_vec(input vec_t v, input int hold,
                           input logic [N-1:0] pend, input bit keep,
                           input int exp_wait);
        int           w;
        bit           got;
        rsp_t         e;
        rsp_t         r;
        logic [511:0] eb;
        logic         cv;
        logic [3:0]   ca;
        logic [63:0]  cd;
        logic         cf;
        req_valid_i[v.id] = 1'b1;
        req_data_i[512*v.id +: 512] = v.blk;
        w = 0;
        got = 0;
        while (!got && w < 20) begin
            #1;
            if (|req_ready_o) got = 1;
            else begin
                w++;
                @(negedge clk);
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL grant_timeout: got none want id %0d", v.id);
            req_valid_i[v.id] = 1'b0;
            return;
        end
        if (exp_wait >= 0) chk("grant_wait", 512'(w), 512'(exp_wait));
        chk("req_ready", 512'(req_ready_o), 512'(4'b1 << v.id));
        chk("rsp_idle", 512'(rsp_valid_o), 512'(0));
        eb = '0;
        for (int c = 0; c < 8 + D; c++) begin
            cmodel(v.mode, c, cv, ca, cd, cf);
            if (cv && ca < 4'd8) eb[64*ca +: 64] = cd;
        end
        e.id    = IW'(v.id);
        e.raw   = v.raw;
        e.words = v.words;
        e.data  = v.raw ? v.blk : eb;
        sbq.push_back(e);
        @(negedge clk);
        if (!keep) req_valid_i[v.id] = 1'b0;
        for (int c = 0; c < 8 + D; c++) begin
            cmodel(v.mode, c, cv, ca, cd, cf);
            comp_valid_i = cv;
            comp_addr_i  = ca;
            comp_data_i  = cd;
            comp_fail_i  = cf;
            #1;
            if (c < 8) begin
                chk("beat_valid", 512'(comp_valid_o), 512'(1));
                chk("beat_sop", 512'(comp_sop_o), 512'(c == 0));
                chk("beat_eop", 512'(comp_eop_o), 512'(c == 7));
                chk("beat_data", 512'(comp_data_o), 512'(v.blk[64*c +: 64]));
            end else begin
                chk("drain_valid", 512'(comp_valid_o), 512'(0));
            end
            chk("busy_rsp", 512'(rsp_valid_o), 512'(0));
            chk("busy_ready", 512'(req_ready_o), 512'(0));
            @(negedge clk);
        end
        comp_valid_i = 1'b0;
        comp_fail_i  = 1'b0;
        req_valid_i  = req_valid_i | pend;
        rsp_ready_i  = 1'b0;
        if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_empty: got empty want entry");
            return;
        end
        r = sbq.pop_front();
        for (int h = 0; h <= hold; h++) begin
            if (h == hold) rsp_ready_i = 1'b1;
            #1;
            chk("rsp_valid", 512'(rsp_valid_o), 512'(1));
            chk("rsp_id", 512'(rsp_id_o), 512'(r.id));
            chk("rsp_raw", 512'(rsp_raw_o), 512'(r.raw));
            chk("rsp_words", 512'(rsp_words_o), 512'(r.words));
            chk("rsp_data", rsp_data_o, r.data);
            chk("rsp_ready_block", 512'(req_ready_o), 512'(0));
            @(negedge clk);
        end
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        vec_t v;
        rst          = 1'b1;
        req_valid_i  = '0;
        req_data_i   = '0;
        comp_valid_i = 1'b0;
        comp_addr_i  = '0;
        comp_data_i  = '0;
        comp_fail_i  = 1'b0;
        rsp_ready_i  = 1'b0;

        tbl[0] = '{0, 512'd0, 0, 1'b0, 4'd1};
        tbl[1] = '{2, {32{16'h0101}}, 1, 1'b1, 4'd8};
        tbl[2] = '{1, {8{64'h0123_4567_89AB_CDEF}}, 2, 1'b0, 4'd4};
        tbl[3] = '{3, {16{32'hFACE_0003}}, 3, 1'b1, 4'd8};
        tbl[4] = '{0, {4{128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100}},
                   4, 1'b0, 4'd3};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_comp_valid", 512'(comp_valid_o), 512'(0));
        chk("reset_rsp_valid", 512'(rsp_valid_o), 512'(0));
        chk("reset_ready", 512'(req_ready_o), 512'(0));
        chk("reset_rsp_data", rsp_data_o, 512'd0);
        chk("reset_rsp_words", 512'(rsp_words_o), 512'(0));
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(tbl[i], 0, '0, 1'b0, -1);
        end

        // Response held back 5 cycles while req3 waits.
        run_vec(tbl[2], 5, 4'b1000, 1'b0, -1);
        v = '{3, {8{64'h3333_0000_5555_AAAA}}, 0, 1'b0, 4'd1};
        run_vec(v, 0, '0, 1'b0, 0);

        // Reset during feed beat 3 of a req1 block.
        req_valid_i[1] = 1'b1;
        req_data_i[512 +: 512] = {16{32'hFEED_0001}};
        #1;
        chk("abort_grant", 512'(req_ready_o), 512'(4'b0010));
        @(negedge clk);
        req_valid_i[1] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_beat3", 512'(comp_data_o), 512'(64'hFEED_0001_FEED_0001));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_comp_valid", 512'(comp_valid_o), 512'(0));
        chk("abort_rsp_valid", 512'(rsp_valid_o), 512'(0));
        comp_valid_i = 1'b1;
        comp_addr_i  = 4'd2;
        comp_data_i  = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        comp_valid_i = 1'b0;
        #1;
        chk("late_word_idle", 512'(comp_valid_o), 512'(0));
        @(negedge clk);
        // Pointer back at 0 must favour req1 over the also-pending req3.
        req_valid_i[3] = 1'b1;
        req_data_i[3*512 +: 512] = {8{64'h0303_0303_0303_0303}};
        v = '{1, {16{32'hFEED_0001}}, 3, 1'b1, 4'd8};
        run_vec(v, 0, '0, 1'b0, 0);
        v = '{3, {8{64'h0303_0303_0303_0303}}, 2, 1'b0, 4'd4};
        run_vec(v, 0, '0, 1'b0, 0);

        // req0 and req1 held: grants alternate 0,1,0,1.
        req_valid_i[0] = 1'b1;
        req_valid_i[1] = 1'b1;
        v = '{0, {8{64'h0000_0000_0000_00F0}}, 0, 1'b0, 4'd1};
        run_vec(v, 0, '0, 1'b1, 0);
        v = '{1, {8{64'h0000_0000_0000_00F1}}, 4, 1'b0, 4'd3};
        run_vec(v, 0, '0, 1'b1, 0);
        v = '{0, {8{64'h0000_0000_0000_00F0}}, 1, 1'b1, 4'd8};
        run_vec(v, 0, '0, 1'b1, 0);
        v = '{1, {8{64'h0000_0000_0000_00F1}}, 2, 1'b0, 4'd4};
        run_vec(v, 0, '0, 1'b1, 0);
        req_valid_i = '0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aidc_lite_comp_sched.md
Name: aidc_lite_comp_sched

Overview:
Shares one ZRLE compressor datapath among NUM_REQ requesters of 512-bit (64 B) blocks. It arbitrates round-robin and serialises the granted block into 8 × 64-bit beats with sop/eop. It captures the compressor's addressed output words into an 8-word buffer and samples the fail flag. It then returns either the compressed block or the raw block (on fail) to the granted requester, using a valid/ready response handshake.

Parameters:
NUM_REQ, 4, number of requesters (≥2).
DRAIN_CYC, 4, cycles waited after eop so compressor output can drain (≥1, ≤15).
ID_W, $clog2(NUM_REQ), requester id width.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid_i  in  NUM_REQ  per-requester block valid
req_data_i  in  NUM_REQ*512  requester r block at [512r+511:512r]
req_ready_o  out  NUM_REQ  one-hot accept pulse
comp_valid_o  out  1  beat valid to compressor
comp_sop_o  out  1  first beat
comp_eop_o  out  1  last beat
comp_data_o  out  64  beat data
comp_valid_i  in  1  compressor output word valid
comp_addr_i  in  4  compressor output word index
comp_data_i  in  64  compressor output word
comp_fail_i  in  1  compressor block-size overflow flag
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  result accept
rsp_id_o  out  ID_W  granted requester
rsp_raw_o  out  1  1 = fail, rsp_data_o is the original block
rsp_words_o  out  4  valid 64-bit words in rsp_data_o (1..8)
rsp_data_o  out  512  word k at [64k+63:64k]

Behaviour:
- Reset: clk only; rst is sync active-high. State IDLE, RR pointer 0, all outputs 0 (buffers/data zero). Reset mid-operation aborts immediately. The next cycle shows comp_valid_o=0 and rsp_valid_o=0. Late compressor words are ignored.
- States: IDLE → FEED → DRAIN → RESP → IDLE.
- IDLE:
  - If any req_valid_i, grant the first requester at or after the pointer (cyclic).
  - Assert req_ready_o[g] combinationally that cycle.
  - Latch the block and g. Clear the word buffer, fail_sticky and max_addr. Set pointer = g+1 mod NUM_REQ.
  - Go to FEED. req_ready_o is 0 in all other states.
- FEED (8 cycles, beat counter 0..7):
  - comp_valid_o=1; comp_data_o = latched[64k+63:64k].
  - sop on k=0, eop on k=7.
  - After k=7, go to DRAIN with drain counter 0.
- DRAIN (DRAIN_CYC cycles), then go to RESP.
- Capture window is FEED and DRAIN:
  - comp_valid_i with addr<8 writes buf[addr] and updates max_addr = max(max_addr, addr).
  - addr≥8 sets fail_sticky.
  - comp_fail_i=1 on any window cycle sets fail_sticky.
  - comp_valid_i outside the window is ignored.
- RESP:
  - rsp_valid_o=1, with all rsp_* fields stable while rsp_ready_i=0.
  - fail_sticky=1: rsp_raw_o=1, rsp_data_o=latched block, rsp_words_o=8.
  - fail_sticky=0 with ≥1 word captured: rsp_raw_o=0, rsp_data_o=buf (unwritten words 0), rsp_words_o=max_addr+1.
  - No word captured and no fail: treat as fail (raw, words=8).
  - On rsp_valid_o&rsp_ready_i, go to IDLE. This gives a one-cycle bubble before the next grant.
- Latency: grant at cycle T; beats T+1..T+8; drain T+9..T+8+DRAIN_CYC; rsp_valid_o first at T+9+DRAIN_CYC.
- Arithmetic:
  - Beat and drain counters are 4-bit.
  - max_addr is 3-bit.
  - Pointer wraps NUM_REQ-1 → 0.
- Requesters are not starved: each valid requester is granted within NUM_REQ grants.

Decomposition:
- Package aidc_lite_sched_pkg:
  - constants BLK_W=512, WORD_W=64, BEATS=8.
  - state enum {S_IDLE,S_FEED,S_DRAIN,S_RESP}.
- Sub-module aidc_lite_rr_arb (NUM_REQ):
  - inputs: request vector, pointer.
  - outputs: one-hot grant, encoded id.
  - purely combinational.
- The pointer register stays in the parent.

Test Plan:
- All-zero block on req0, DRAIN_CYC=4:
  - Required comp beats: sop at T+1, eop at T+8, all data 0.
  - Compressor model returns one word at addr 0.
  - Required response at T+13: rsp_raw_o=0, rsp_words_o=1, id=0.
- Block with all 16-bit lanes nonzero (e.g. 0x0101… pattern) on req2:
  - Model asserts comp_fail_i and emits 9 words (addr 0..8).
  - Required response: rsp_raw_o=1, rsp_words_o=8, rsp_data_o equals the input block.
- req0 and req1 held valid continuously:
  - Required grant order 0,1,0,1.
  - Check that req_ready_o is one-hot and that there is one idle cycle between RESP handshake and the next grant.
- Hold rsp_ready_i=0 for 5 cycles in RESP:
  - rsp_* stay stable.
  - req_ready_o stays 0 despite pending req3.
  - Grant to req3 occurs the cycle after the handshake.
- Assert rst during FEED beat 3:
  - Next cycle: comp_valid_o=0, rsp_valid_o=0.
  - A compressor word arriving afterwards is ignored.
  - A new req1 block then completes normally with pointer restarted at 0.
- Compressor word with addr=3 only, no fail:
  - rsp_words_o=4.
  - Words 0,1,2 read 0; word 3 equals the captured data.
